// File: rtl/alu_pkg.sv
// Shared encodings for the multi-byte sequencer and the 8-bit ALU it drives.
// Pure definitions; no logic, no latency, no flow control.
// Command codes, alu8 op words, flag bit positions and sequencer states.
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_ADD = 3'b000,
        CMD_ADC = 3'b001,
        CMD_SUB = 3'b010,
        CMD_SBC = 3'b011,
        CMD_AND = 3'b100,
        CMD_OR  = 3'b101,
        CMD_XOR = 3'b110,
        CMD_CMP = 3'b111
    } cmd_e;

    // alu8 op is {k,i,j,c_in}; carry-in is OR'd into bit 0
    localparam logic [3:0] ALU_ADD = 4'b1100;
    localparam logic [3:0] ALU_SUB = 4'b1110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0010;

    localparam int FLG_N = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu8_wide_seq.sv
// Multi-byte ALU sequencer: walks an external alu8 LSB-first, chaining carry, builds word flags.
// Latency: accept at cycle 0, out_valid at cycle NBYTES+1; one transaction in flight.
// Backpressure: in_ready only in IDLE; result/flags held stable until out_ready.
module alu8_wide_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_cmd,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_res,
    output logic [3:0]            out_flg,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [3:0]            alu_op,
    input  logic [7:0]            alu_res,
    input  logic [3:0]            alu_flg
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e           state_q, state_d;
    cmd_e             cmd_q;
    logic [W-1:0]     a_q, b_q, res_q;
    logic [IDX_W-1:0] idx_q;
    logic             chain_c_q;
    logic             stored_c_q;

    logic             is_logic, is_sub, last_pass;
    logic [W-1:0]     res_word;
    logic [3:0]       flg_word;
    logic             c_in;
    logic [3:0]       op_base;

    // alu8's own z/v/n are per-byte and not usable for word flags
    logic unused_alu_flg;
    assign unused_alu_flg = ^alu_flg[2:0];

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    assign is_logic  = (cmd_q == CMD_AND) || (cmd_q == CMD_OR) || (cmd_q == CMD_XOR);
    assign is_sub    = (cmd_q == CMD_SUB) || (cmd_q == CMD_SBC) || (cmd_q == CMD_CMP);
    assign last_pass = (idx_q == LAST_IDX);

    // Full word as it will look once this pass's byte is captured
    always_comb begin
        res_word = res_q;
        res_word[idx_q*8 +: 8] = alu_res;
    end

    always_comb begin
        flg_word        = '0;
        flg_word[FLG_C] = is_logic ? 1'b0 : alu_flg[FLG_C];
        flg_word[FLG_Z] = (res_word == '0);
        flg_word[FLG_N] = res_word[W-1];
        if (!is_logic) begin
            if (is_sub)
                flg_word[FLG_V] = (a_q[W-1] != b_q[W-1]) && (res_word[W-1] != a_q[W-1]);
            else
                flg_word[FLG_V] = (a_q[W-1] == b_q[W-1]) && (res_word[W-1] != a_q[W-1]);
        end
    end

    always_comb begin
        op_base = ALU_ADD;
        unique case (cmd_q)
            CMD_ADD, CMD_ADC:          op_base = ALU_ADD;
            CMD_SUB, CMD_SBC, CMD_CMP: op_base = ALU_SUB;
            CMD_AND:                   op_base = ALU_AND;
            CMD_OR:                    op_base = ALU_OR;
            CMD_XOR:                   op_base = ALU_XOR;
            default:                   op_base = ALU_ADD;
        endcase
    end

    // Pass 0 seeds the carry from the command; later passes take the chain
    always_comb begin
        c_in = 1'b0;
        if (is_logic)
            c_in = 1'b0;
        else if (idx_q != '0)
            c_in = chain_c_q;
        else if (cmd_q == CMD_ADC || cmd_q == CMD_SBC)
            c_in = stored_c_q;
        else
            c_in = is_sub;
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (state_q == ST_BUSY) begin
            alu_a  = a_q[idx_q*8 +: 8];
            alu_b  = b_q[idx_q*8 +: 8];
            alu_op = op_base | {3'b000, c_in};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_BUSY;
            ST_BUSY: if (last_pass) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_ADD;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            idx_q      <= '0;
            chain_c_q  <= 1'b0;
            stored_c_q <= 1'b0;
            out_res    <= '0;
            out_flg    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                cmd_q <= cmd_e'(in_cmd);
                a_q   <= in_a;
                b_q   <= in_b;
                idx_q <= '0;
            end
            if (state_q == ST_BUSY) begin
                res_q     <= res_word;
                chain_c_q <= alu_flg[FLG_C];
                if (last_pass) begin
                    out_res <= (cmd_q == CMD_CMP) ? a_q : res_word;
                    out_flg <= flg_word;
                    if (!is_logic)
                        stored_c_q <= flg_word[FLG_C];
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu8_wide_seq.sv
// Bench for alu8_wide_seq with a behavioural alu8 beside it and a word-level reference model.
module tb_alu8_wide_seq;
    import alu_pkg::*;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   in_cmd;
    logic [W-1:0] in_a, in_b, out_res;
    logic [3:0]   out_flg;
    logic [7:0]   alu_a, alu_b, alu_res;
    logic [3:0]   alu_op, alu_flg;
    logic [8:0]   alu_tmp;

    int n_cmp = 0;
    int n_bad = 0;
    logic model_sc;

    always #5 clk = ~clk;

    alu8_wide_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flg(out_flg),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_flg(alu_flg)
    );

    // Behavioural alu8: op {k,i,j,c_in}; flags {c, z(byte), v(uninverted b), n}
    always_comb begin
        alu_tmp = '0;
        case (alu_op[3:1])
            3'b110:  alu_tmp = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_op[0]};
            3'b111:  alu_tmp = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'b0, alu_op[0]};
            3'b000:  alu_tmp = {1'b0, alu_a & alu_b};
            3'b010:  alu_tmp = {1'b0, alu_a | alu_b};
            3'b001:  alu_tmp = {1'b0, alu_a ^ alu_b};
            default: alu_tmp = '0;
        endcase
        alu_res = alu_tmp[7:0];
        alu_flg = {alu_tmp[8], alu_tmp[7:0] == 8'h00,
                   (alu_a[7] == alu_b[7]) && (alu_tmp[7] != alu_a[7]), alu_tmp[7]};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Word-level reference: plain W-bit arithmetic with the stored carry kept here
    task automatic model(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [3:0] f);
        logic [W:0] s;
        logic arith, subop, c, v;
        arith = (cmd == CMD_ADD) || (cmd == CMD_ADC) || (cmd == CMD_SUB) ||
                (cmd == CMD_SBC) || (cmd == CMD_CMP);
        subop = (cmd == CMD_SUB) || (cmd == CMD_SBC) || (cmd == CMD_CMP);
        case (cmd)
            CMD_ADD: s = {1'b0, a} + {1'b0, b};
            CMD_ADC: s = {1'b0, a} + {1'b0, b} + (W+1)'(model_sc);
            CMD_SUB: s = {1'b0, a} - {1'b0, b} + (W+1)'(1 << W);
            CMD_SBC: s = {1'b0, a} + {1'b0, ~b} + (W+1)'(model_sc);
            CMD_CMP: s = {1'b0, a} - {1'b0, b} + (W+1)'(1 << W);
            CMD_AND: s = {1'b0, a & b};
            CMD_OR:  s = {1'b0, a | b};
            default: s = {1'b0, a ^ b};
        endcase
        r = s[W-1:0];
        c = arith ? s[W] : 1'b0;
        if (!arith)
            v = 1'b0;
        else if (subop)
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        f = {c, r == '0, v, r[W-1]};
        if (arith) model_sc = c;
        if (cmd == CMD_CMP) r = a;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("out_valid_timeout", out_valid, 1);
    endtask

    // Called at posedge+1 in IDLE; captures per-pass alu drive for inspection
    task automatic run_txn(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, output logic [W-1:0] r, output logic [3:0] f,
                           output logic [4*NB-1:0] ops, output logic [7:0] a0, output logic [7:0] b0);
        in_cmd = cmd; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a0 = alu_a; b0 = alu_b;
        for (int i = 0; i < NB; i++) begin
            ops[4*i +: 4] = alu_op;
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        check("latency_out_valid", out_valid, 1);
        if (!out_valid) wait_valid();
        r = out_res; f = out_flg;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_res", out_res, r);
            check("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
    endtask

    task automatic txn_check(input string nm, input logic [2:0] cmd, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int hold);
        logic [W-1:0] er, r;
        logic [3:0] ef, f;
        logic [4*NB-1:0] ops;
        logic [7:0] a0, b0;
        model(cmd, a, b, er, ef);
        run_txn(cmd, a, b, hold, r, f, ops, a0, b0);
        check({nm, "_res"}, r, er);
        check({nm, "_flg"}, f, ef);
    endtask

    typedef struct {
        logic [2:0]   cmd;
        logic [W-1:0] a, b, res;
        logic [3:0]   flg;
    } vec_t;

    vec_t vt[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, er, hold_r;
        logic [3:0] f, ef, hold_f;
        logic [4*NB-1:0] ops;
        logic [7:0] a0, b0;

        vt[0] = '{CMD_ADD, 16'h12FF, 16'h0001, 16'h1300, 4'b0000};
        vt[1] = '{CMD_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1010};
        vt[2] = '{CMD_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100};
        vt[3] = '{CMD_XOR, 16'hA5A5, 16'hA5A5, 16'h0000, 4'b0100};
        vt[4] = '{CMD_ADC, 16'h0000, 16'h0000, 16'h0001, 4'b0000};
        vt[5] = '{CMD_CMP, 16'h0005, 16'h0007, 16'h0005, 4'b0001};
        vt[6] = '{CMD_SBC, 16'h0010, 16'h0001, 16'h000E, 4'b1000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_cmd = '0; in_a = '0; in_b = '0; model_sc = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_flg", out_flg, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            model(vt[i].cmd, vt[i].a, vt[i].b, er, ef);
            run_txn(vt[i].cmd, vt[i].a, vt[i].b, 0, r, f, ops, a0, b0);
            check($sformatf("vec%0d_res", i), r, vt[i].res);
            check($sformatf("vec%0d_flg", i), f, vt[i].flg);
            if (i == 0) begin
                check("add_pass0_op", ops[3:0], 4'b1100);
                check("add_pass1_op", ops[7:4], 4'b1101);
                check("add_pass0_a", a0, 8'hFF);
                check("add_pass0_b", b0, 8'h01);
            end
            if (i == 1) begin
                check("sub_pass0_op", ops[3:0], 4'b1111);
                check("sub_pass1_op", ops[7:4], 4'b1110);
            end
            if (i == 3) check("xor_pass1_op", ops[7:4], 4'b0010);
        end

        // Output backpressure with a competing command that must be ignored
        in_cmd = CMD_ADD; in_a = 16'h1234; in_b = 16'h0F0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid();
        hold_r = out_res; hold_f = out_flg;
        check("bp_res", hold_r, 16'h2143);
        check("bp_flg", hold_f, 4'b0000);
        in_cmd = CMD_SUB; in_a = 16'h4444; in_b = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_res", out_res, hold_r);
            check("bp_hold_flg", out_flg, hold_f);
            check("bp_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("bp_no_ghost_op", alu_op, 0);
        check("bp_no_ghost_ready", in_ready, 1);
        model_sc = 1'b0;

        // Reset mid-transaction after stored carry has been set
        txn_check("prerst_add", CMD_ADD, 16'hFFFF, 16'h0001, 0);
        in_cmd = CMD_SUB; in_a = 16'h0300; in_b = 16'h0100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst_busy_op", alu_op, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        model_sc = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_in_ready", in_ready, 1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("postrst_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        txn_check("postrst_adc", CMD_ADC, 16'h0000, 16'h0000, 0);
        txn_check("postrst_add", CMD_ADD, 16'h7FFF, 16'h0001, 1);

        for (int i = 0; i < 200; i++) begin
            logic [2:0] c;
            logic [W-1:0] ra, rb;
            c  = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = ra;
            txn_check($sformatf("rnd%0d", i), c, ra, rb, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
